bist_sig_checker: RTL and testbench

BIST_SIG_CHECKER -- requirements
Module: bist_sig_checker

---
 rtl/bist_sig_checker_pkg.sv | 25 ++
 rtl/bist_sig_checker_misr.sv | 40 ++++
 rtl/bist_sig_checker.sv | 133 +++++++++++++
 tb/tb_bist_sig_checker.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/bist_sig_checker_pkg.sv
// Shared BIST definitions: FSM encoding, ASCII status words, MISR polynomial
// and the signature step function used by every BIST wrapper.
package bist_sig_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_EVAL = 2'd2
    } bist_state_e;

    localparam logic [31:0] RES_NONE = 32'h0000_0000;
    localparam logic [31:0] RES_PASS = 32'h5041_5353;
    localparam logic [31:0] RES_FAIL = 32'h4641_494C;
    localparam logic [31:0] RES_LRND = 32'h4C52_4E44;
    localparam logic [31:0] RES_ABRT = 32'h4142_5254;

    // x^8 + x^4 + x^3 + x^2 + 1 with the x^8 term implied
    localparam logic [7:0] MISR_TAPS   = 8'h1D;
    localparam logic [7:0] GOLDEN_RST  = 8'hDE;

    function automatic logic [7:0] misr_step(input logic [7:0] s, input logic [7:0] d);
        misr_step = {s[6:0], 1'b0} ^ (s[7] ? MISR_TAPS : 8'h00) ^ d;
    endfunction

endpackage

// File: rtl/bist_sig_checker_misr.sv
// misr8: 8-bit multiple-input signature register, reusable across BIST wrappers.
// clr has priority over en; both act on the rising edge.
module misr8
    import bist_sig_checker_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] d,
    output logic [7:0] sig
);

    logic [7:0] sig_q;
    logic [7:0] sig_d;

    // next-signature selection
    always_comb begin
        sig_d = sig_q;
        if (clr) begin
            sig_d = 8'h00;
        end else if (en) begin
            sig_d = misr_step(sig_q, d);
        end else begin
            sig_d = sig_q;
        end
    end

    // signature register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= 8'h00;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/bist_sig_checker.sv
// BIST signature checker: compacts NPAT CUT response beats into a MISR and
// either learns the result as golden or compares it against the stored golden.
module bist_sig_checker
    import bist_sig_checker_pkg::*;
#(
    parameter int NPAT = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mode,
    input  logic        abort,
    input  logic        resp_valid,
    input  logic [7:0]  resp_data,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [31:0] result,
    output logic [7:0]  signature,
    output logic [7:0]  golden
);

    localparam logic [15:0] NPAT_W = 16'(NPAT);

    bist_state_e state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        mode_q, mode_d;
    logic        pass_q, pass_d;
    logic        done_q, done_d;
    logic [31:0] result_q, result_d;
    logic [7:0]  golden_q, golden_d;
    logic        misr_clr_s;
    logic        misr_en_s;
    logic [7:0]  sig_s;

    misr8 u_misr (
        .clk (clk),
        .rst (rst),
        .clr (misr_clr_s),
        .en  (misr_en_s),
        .d   (resp_data),
        .sig (sig_s)
    );

    // FSM next-state and datapath control
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mode_d     = mode_q;
        pass_d     = pass_q;
        done_d     = 1'b0;
        result_d   = result_q;
        golden_d   = golden_q;
        misr_clr_s = 1'b0;
        misr_en_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_RUN;
                    cnt_d      = 16'd0;
                    mode_d     = mode;
                    pass_d     = 1'b0;
                    misr_clr_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // abort wins over a coincident beat, which is then dropped
                if (abort) begin
                    state_d  = ST_IDLE;
                    result_d = RES_ABRT;
                    pass_d   = 1'b0;
                    done_d   = 1'b1;
                end else if (resp_valid) begin
                    misr_en_s = 1'b1;
                    cnt_d     = cnt_q + 16'd1;
                    if (cnt_d == NPAT_W) begin
                        state_d = ST_EVAL;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_EVAL: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                if (mode_q) begin
                    golden_d = sig_s;
                    result_d = RES_LRND;
                    pass_d   = 1'b0;
                end else begin
                    pass_d   = (sig_s == golden_q);
                    result_d = (sig_s == golden_q) ? RES_PASS : RES_FAIL;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // state and status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 16'd0;
            mode_q   <= 1'b0;
            pass_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= RES_NONE;
            golden_q <= GOLDEN_RST;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            pass_q   <= pass_d;
            done_q   <= done_d;
            result_q <= result_d;
            golden_q <= golden_d;
        end
    end

    assign busy      = (state_q == ST_RUN) || (state_q == ST_EVAL);
    assign done      = done_q;
    assign pass      = pass_q;
    assign result    = result_q;
    assign signature = sig_s;
    assign golden    = golden_q;

endmodule

// File: tb/tb_bist_sig_checker.sv
// Randomized self-checking bench for bist_sig_checker against a polynomial
// reference model; a second instance with NPAT=2 covers the short-run case.
module tb_bist_sig_checker;

    localparam int NPAT = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, mode, abort, resp_valid;
    logic [7:0]  resp_data;
    logic        busy, done, pass;
    logic [31:0] result;
    logic [7:0]  signature, golden;

    logic        start2, mode2, abort2, valid2;
    logic [7:0]  data2;
    logic        busy2, done2, pass2;
    logic [31:0] result2;
    logic [7:0]  sig2, golden2;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  m_golden;
    logic [31:0] m_result;
    logic        m_pass;

    bist_sig_checker #(.NPAT(NPAT)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort),
        .resp_valid(resp_valid), .resp_data(resp_data), .busy(busy), .done(done),
        .pass(pass), .result(result), .signature(signature), .golden(golden)
    );

    bist_sig_checker #(.NPAT(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .mode(mode2), .abort(abort2),
        .resp_valid(valid2), .resp_data(data2), .busy(busy2), .done(done2),
        .pass(pass2), .result(result2), .signature(sig2), .golden(golden2)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Signature as polynomial arithmetic: s*x mod (x^8+x^4+x^3+x^2+1) plus data
    function automatic logic [7:0] ref_misr(input logic [7:0] s, input logic [7:0] d);
        logic [8:0] t;
        t = {s, 1'b0};
        if (t[8]) t = t ^ 9'h11D;
        return t[7:0] ^ d;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // gap: 0 = valid every cycle, 1 = every other cycle, 2 = random
    task automatic run(input logic m, input int gap, input logic zeros,
                       input int abort_beat, input int rst_beat);
        logic [7:0] s;
        logic [7:0] d;
        logic       v, ab, rs;
        int         cnt, cyc;
        start = 1'b1; mode = m;
        step();
        start = 1'b0; mode = ~m;
        check_val("busy_after_start", busy, 32'd1);
        check_val("sig_cleared", signature, 32'h00);
        s = 8'h00; cnt = 0; cyc = 0; ab = 1'b0; rs = 1'b0;
        while (cnt < NPAT && !ab && !rs && cyc < 4 * NPAT + 16) begin
            v = (gap == 0) ? 1'b1 : (gap == 1) ? cyc[0] : 1'($urandom_range(0, 1));
            d = zeros ? 8'h00 : 8'($urandom);
            ab = v && (abort_beat > 0) && (cnt + 1 == abort_beat);
            resp_valid = v; resp_data = d; abort = ab; start = (cyc == 5);
            step();
            resp_valid = 1'b0; abort = 1'b0; start = 1'b0;
            cyc++;
            if (!ab && v) begin
                s = ref_misr(s, d);
                cnt++;
            end
            if (!ab) begin
                check_val("busy_in_run", busy, 32'd1);
                check_val("no_early_done", done, 32'd0);
            end
            if (rst_beat > 0 && cnt == rst_beat) begin
                #2 rst = 1'b1;
                #1;
                rs = 1'b1;
            end
        end
        if (rs) begin
            check_val("rst_busy", busy, 32'd0);
            check_val("rst_done", done, 32'd0);
            check_val("rst_pass", pass, 32'd0);
            check_val("rst_result", result, 32'h0);
            check_val("rst_sig", signature, 32'h00);
            check_val("rst_golden", golden, 32'hDE);
            step();
            rst = 1'b0;
            m_golden = 8'hDE; m_result = 32'h0; m_pass = 1'b0;
        end else if (ab) begin
            m_result = 32'h41425254; m_pass = 1'b0;
            check_val("abort_beats", cnt, abort_beat - 1);
            check_val("abort_busy", busy, 32'd0);
            check_val("abort_done", done, 32'd1);
            check_val("abort_result", result, m_result);
            check_val("abort_pass", pass, 32'(m_pass));
            check_val("abort_sig", signature, 32'(s));
            check_val("abort_golden", golden, 32'(m_golden));
            step();
            check_val("abort_done_end", done, 32'd0);
        end else if (cnt == NPAT) begin
            check_val("eval_sig", signature, 32'(s));
            step();
            check_val("done_pulse", done, 32'd1);
            check_val("idle_after_eval", busy, 32'd0);
            if (m) begin
                m_golden = s; m_result = 32'h4C524E44; m_pass = 1'b0;
            end else begin
                m_pass = (s == m_golden);
                m_result = m_pass ? 32'h50415353 : 32'h4641494C;
            end
            check_val("result", result, m_result);
            check_val("pass", pass, 32'(m_pass));
            check_val("golden", golden, 32'(m_golden));
            step();
            check_val("done_one_cycle", done, 32'd0);
            // IDLE must ignore beats and abort and hold every status output
            for (int i = 0; i < 3; i++) begin
                resp_valid = 1'b1; resp_data = 8'($urandom); abort = 1'b1;
                step();
            end
            resp_valid = 1'b0; abort = 1'b0;
            check_val("idle_hold_sig", signature, 32'(s));
            check_val("idle_hold_result", result, m_result);
            check_val("idle_hold_pass", pass, 32'(m_pass));
            check_val("idle_hold_golden", golden, 32'(m_golden));
        end else begin
            check_val("run_timeout", cnt, NPAT);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0; mode = 1'b0; abort = 1'b0; resp_valid = 1'b0; resp_data = 8'h00;
        start2 = 1'b0; mode2 = 1'b0; abort2 = 1'b0; valid2 = 1'b0; data2 = 8'h00;
        m_golden = 8'hDE; m_result = 32'h0; m_pass = 1'b0;
        step(); step();
        check_val("reset_result", result, 32'h0);
        check_val("reset_golden", golden, 32'hDE);
        check_val("reset_busy", busy, 32'd0);
        check_val("reset_done", done, 32'd0);
        rst = 1'b0;
        step();

        // NPAT=2 instance: beats 01 then 80
        start2 = 1'b1; mode2 = 1'b1;
        step();
        start2 = 1'b0; valid2 = 1'b1; data2 = 8'h01;
        step();
        check_val("n2_sig_beat1", sig2, 32'h01);
        data2 = 8'h80;
        step();
        valid2 = 1'b0;
        check_val("n2_sig_beat2", sig2, 32'h82);
        check_val("n2_ref_beat2", sig2, 32'(ref_misr(ref_misr(8'h00, 8'h01), 8'h80)));
        check_val("n2_busy_eval", busy2, 32'd1);
        step();
        check_val("n2_done", done2, 32'd1);
        check_val("n2_golden", golden2, 32'h82);

        run(1'b0, 0, 1'b1, 0, 0);   // check vs reset golden -> FAIL
        run(1'b1, 0, 1'b1, 0, 0);   // learn zeros -> golden 00
        run(1'b0, 0, 1'b1, 0, 0);   // check zeros -> PASS
        run(1'b1, 1, 1'b0, 0, 0);   // learn, beats every other cycle
        run(1'b0, 2, 1'b0, 0, 0);   // check, random gaps and data
        run(1'b0, 2, 1'b0, 100, 0); // abort on beat 100
        run(1'b1, 2, 1'b0, 0, 50);  // reset after beat 50
        run(1'b1, 2, 1'b0, 0, 0);
        run(1'b0, 0, 1'b0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
